// File: rtl/bank_pkg.sv
// Shared bank-side definitions: field widths, output-stage state and the
// crossbar response payload.
package bank_pkg;

   localparam int unsigned CHANNEL_W   = 2;
   localparam int unsigned ROB_NUM_W   = 3;
   localparam int unsigned NUM_CHANNEL = 4;
   localparam int unsigned BANK_ID_W   = 3;
   localparam int unsigned XBAR_DATA_W = 128;
   localparam int unsigned PERF_CNT_W  = 16;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } stage_state_e;

   typedef struct packed {
      logic [BANK_ID_W-1:0]   bank_id;
      logic [CHANNEL_W-1:0]   channel_id;
      logic [ROB_NUM_W-1:0]   rob_num;
      logic [XBAR_DATA_W-1:0] data;
   } xbar_rsp_t;

endpackage

// File: rtl/bank_xbar_rsp_arb_if.sv
// Bank response ports plus the shared crossbar response port.
// master: arbiter view; slave: bank/crossbar environment view.
interface bank_xbar_rsp_arb_if
   import bank_pkg::*;
#(
   parameter int unsigned NUM_BANK = 4,
   parameter int unsigned DATA_W   = 128
);

   logic [NUM_BANK-1:0]           bank_valid_i;
   logic [NUM_BANK-1:0]           bank_ready_o;
   logic [NUM_BANK*CHANNEL_W-1:0] bank_channel_id_i;
   logic [NUM_BANK*ROB_NUM_W-1:0] bank_rob_num_i;
   logic [NUM_BANK*DATA_W-1:0]    bank_data_i;
   logic [NUM_CHANNEL-1:0]        xbar_chan_busy_i;
   logic                          xbar_valid_o;
   logic                          xbar_ready_i;
   logic [BANK_ID_W-1:0]          xbar_bank_id_o;
   logic [CHANNEL_W-1:0]          xbar_channel_id_o;
   logic [ROB_NUM_W-1:0]          xbar_rob_num_o;
   logic [DATA_W-1:0]             xbar_data_o;

   modport master (
      input  bank_valid_i,
      output bank_ready_o,
      input  bank_channel_id_i,
      input  bank_rob_num_i,
      input  bank_data_i,
      input  xbar_chan_busy_i,
      output xbar_valid_o,
      input  xbar_ready_i,
      output xbar_bank_id_o,
      output xbar_channel_id_o,
      output xbar_rob_num_o,
      output xbar_data_o
   );

   modport slave (
      output bank_valid_i,
      input  bank_ready_o,
      output bank_channel_id_i,
      output bank_rob_num_i,
      output bank_data_i,
      output xbar_chan_busy_i,
      input  xbar_valid_o,
      output xbar_ready_i,
      input  xbar_bank_id_o,
      input  xbar_channel_id_o,
      input  xbar_rob_num_o,
      input  xbar_data_o
   );

endinterface

// File: rtl/bank_rr_picker.sv
// Combinational round-robin priority picker: grants the first requester at
// or after the pointer, searching upward modulo N.
module bank_rr_picker #(
   parameter int unsigned N     = 4,
   parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     i_req,
   input  logic [IDX_W-1:0] i_ptr,
   output logic [N-1:0]     o_gnt,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_any
);

   logic [IDX_W-1:0] w_j;

   // Rotating scan from the pointer; the first hit wins.
   always_comb begin
      o_gnt = '0;
      o_idx = '0;
      o_any = 1'b0;
      w_j   = '0;
      for (int unsigned k = 0; k < N; k++) begin
         w_j = IDX_W'((32'(i_ptr) + k) % N);
         if (!o_any && i_req[w_j]) begin
            o_any      = 1'b1;
            o_gnt[w_j] = 1'b1;
            o_idx      = w_j;
         end
      end
   end

endmodule

// File: rtl/bank_xbar_rsp_arb.sv
// Round-robin arbiter sharing the crossbar response port among cache-bank
// SRAM controllers, with a one-entry registered output stage.
// Optional macro BANK_XBAR_RSP_ARB_PERF_EN adds per-bank saturating grant
// counters on perf_grant_cnt_o.
module bank_xbar_rsp_arb
   import bank_pkg::*;
#(
   parameter int unsigned NUM_BANK = 4,
   parameter int unsigned DATA_W   = 128
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   bank_xbar_rsp_arb_if.master        bus
`ifdef BANK_XBAR_RSP_ARB_PERF_EN
   ,
   output logic [NUM_BANK*PERF_CNT_W-1:0] perf_grant_cnt_o
`endif
);

   localparam int unsigned IDX_W = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1;

   logic [NUM_BANK-1:0] w_elig;
   logic [NUM_BANK-1:0] w_req;
   logic [NUM_BANK-1:0] w_gnt;
   logic [IDX_W-1:0]    w_gnt_idx;
   logic                w_gnt_any;
   logic                w_load_ok;
   logic                w_drain;

   stage_state_e        r_state;
   stage_state_e        w_state_nxt;
   logic [IDX_W-1:0]    r_rr_ptr;
   logic [IDX_W-1:0]    w_rr_ptr_nxt;
   xbar_rsp_t           r_rsp;
   xbar_rsp_t           w_rsp_nxt;

   // A bank is eligible when valid and its target channel is not busy.
   always_comb begin
      w_elig = '0;
      for (int unsigned i = 0; i < NUM_BANK; i++) begin
         w_elig[i] = bus.bank_valid_i[i] &
                     ~bus.xbar_chan_busy_i[bus.bank_channel_id_i[i*CHANNEL_W +: CHANNEL_W]];
      end
   end

   // Output stage accepts a new beat when empty or draining this cycle;
   // reset suppresses every grant.
   always_comb begin
      w_drain   = (r_state == ST_FULL) & bus.xbar_ready_i;
      w_load_ok = (r_state == ST_EMPTY) | bus.xbar_ready_i;
      w_req     = (w_load_ok & ~rst_i) ? w_elig : '0;
   end

   bank_rr_picker #(
      .N     (NUM_BANK),
      .IDX_W (IDX_W)
   ) u_picker (
      .i_req (w_req),
      .i_ptr (r_rr_ptr),
      .o_gnt (w_gnt),
      .o_idx (w_gnt_idx),
      .o_any (w_gnt_any)
   );

   assign bus.bank_ready_o = w_gnt;

   // Output-stage next state, payload load and round-robin pointer advance.
   always_comb begin
      w_state_nxt  = r_state;
      w_rr_ptr_nxt = r_rr_ptr;
      w_rsp_nxt    = r_rsp;
      case (r_state)
         ST_EMPTY: if (w_gnt_any) w_state_nxt = ST_FULL;
         ST_FULL:  if (w_drain && !w_gnt_any) w_state_nxt = ST_EMPTY;
         default:  w_state_nxt = ST_EMPTY;
      endcase
      if (w_gnt_any) begin
         w_rsp_nxt.bank_id    = BANK_ID_W'(w_gnt_idx);
         w_rsp_nxt.channel_id = bus.bank_channel_id_i[int'(w_gnt_idx)*CHANNEL_W +: CHANNEL_W];
         w_rsp_nxt.rob_num    = bus.bank_rob_num_i[int'(w_gnt_idx)*ROB_NUM_W +: ROB_NUM_W];
         w_rsp_nxt.data       = XBAR_DATA_W'(bus.bank_data_i[int'(w_gnt_idx)*DATA_W +: DATA_W]);
         w_rr_ptr_nxt         = (w_gnt_idx == IDX_W'(NUM_BANK - 1)) ? '0
                                                                  : w_gnt_idx + IDX_W'(1);
      end
   end

   // State, pointer and payload registers; reset discards any held beat.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state  <= ST_EMPTY;
         r_rr_ptr <= '0;
         r_rsp    <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_rr_ptr <= w_rr_ptr_nxt;
         r_rsp    <= w_rsp_nxt;
      end
   end

   assign bus.xbar_valid_o      = (r_state == ST_FULL);
   assign bus.xbar_bank_id_o    = r_rsp.bank_id;
   assign bus.xbar_channel_id_o = r_rsp.channel_id;
   assign bus.xbar_rob_num_o    = r_rsp.rob_num;
   assign bus.xbar_data_o       = DATA_W'(r_rsp.data);

`ifdef BANK_XBAR_RSP_ARB_PERF_EN
   logic [PERF_CNT_W-1:0] r_perf_cnt [NUM_BANK];

   // Per-bank grant counters, saturating at all-ones.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < NUM_BANK; i++) r_perf_cnt[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_BANK; i++) begin
            if (w_gnt[i] && (r_perf_cnt[i] != {PERF_CNT_W{1'b1}}))
               r_perf_cnt[i] <= r_perf_cnt[i] + PERF_CNT_W'(1);
         end
      end
   end

   // Flatten counters onto the perf port.
   always_comb begin
      perf_grant_cnt_o = '0;
      for (int unsigned i = 0; i < NUM_BANK; i++)
         perf_grant_cnt_o[i*PERF_CNT_W +: PERF_CNT_W] = r_perf_cnt[i];
   end
`endif

endmodule
